// File: rtl/dma_hold_ctrl_pkg.sv
// Shared types and default constants for the DMA HOLD/HLDA bus-ownership logic.
package dma_hold_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    DELAY   = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } hold_state_t;

  localparam int HLDA_DELAY_DEF     = 1;
  localparam int CPU_MIN_CYCLES_DEF = 1;
  localparam int WDOG_MAX_DEF       = 1024;
  localparam int WDOG_W_DEF         = 11;

endpackage

// File: rtl/dma_hold_ctrl_watchdog.sv
// Hold-duration watchdog: counts GRANT cycles and raises a sticky error at WDOG_MAX.
// Compiled only when HOLD_WATCHDOG_EN is defined.
`ifdef HOLD_WATCHDOG_EN
module hold_watchdog
  import dma_hold_ctrl_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF,
  parameter int WDOG_W   = WDOG_W_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_run,
  output logic o_err
);

  localparam logic [WDOG_W-1:0] CNT_MAX  = WDOG_W'(WDOG_MAX);
  localparam logic [WDOG_W-1:0] CNT_ONE  = WDOG_W'(1);
  localparam logic [WDOG_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  logic [WDOG_W-1:0] r_cnt;
  logic              r_err;

  // The error is flagged on the same edge the counter reaches WDOG_MAX.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!i_run)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_ONE;
      if (i_run && (r_cnt == CNT_LAST))
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule
`endif

// File: rtl/dma_hold_ctrl.sv
// HOLD/HLDA responder: hands the bus to the DMA once the CPU cycle and lock clear.
// Optional hold watchdog is built when HOLD_WATCHDOG_EN is defined.
module dma_hold_ctrl
  import dma_hold_ctrl_pkg::*;
#(
  parameter int HLDA_DELAY     = HLDA_DELAY_DEF,
  parameter int CPU_MIN_CYCLES = CPU_MIN_CYCLES_DEF,
  parameter int WDOG_MAX       = WDOG_MAX_DEF,
  parameter int WDOG_W         = WDOG_W_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic hrq,
  input  logic cpuBusReq,
  input  logic cpuCycleActive,
  input  logic cpuLock,
  output logic hlda,
  output logic cpuGrant,
  output logic holdErr
);

  if ((HLDA_DELAY < 0) || (HLDA_DELAY > 15) || (CPU_MIN_CYCLES < 0) ||
      (CPU_MIN_CYCLES > 15) || ((2 ** WDOG_W) <= WDOG_MAX)) begin : g_bad_cfg
    $error("dma_hold_ctrl: parameter out of range");
  end

  localparam logic [3:0] DLY_LOAD  = 4'(HLDA_DELAY);
  // The RELEASE->IDLE edge already gives the CPU its first grant cycle.
  localparam logic [3:0] FAIR_LOAD = (CPU_MIN_CYCLES > 0) ? 4'(CPU_MIN_CYCLES - 1) : 4'd0;

  hold_state_t r_state;
  hold_state_t w_state_nxt;
  hold_state_t w_arm_state;
  logic [3:0]  r_dly_cnt;
  logic [3:0]  r_fair_cnt;
  logic        r_hlda;
  logic        r_cpu_grant;
  logic        w_bus_busy;
  logic        w_fair_block;
  logic        w_hlda_nxt;
  logic        w_grant_nxt;

  assign w_bus_busy   = cpuCycleActive | cpuLock;
  assign w_fair_block = (r_fair_cnt != 4'd0) && cpuBusReq;
  assign w_arm_state  = (HLDA_DELAY == 0) ? GRANT : DELAY;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (hrq && !w_fair_block)
          w_state_nxt = w_bus_busy ? DRAIN : w_arm_state;
      end
      DRAIN: begin
        if (!hrq)
          w_state_nxt = IDLE;
        else if (!w_bus_busy)
          w_state_nxt = w_arm_state;
      end
      DELAY: begin
        if (!hrq)
          w_state_nxt = IDLE;
        else if (w_bus_busy)
          w_state_nxt = DRAIN;
        else if (r_dly_cnt <= 4'd1)
          w_state_nxt = GRANT;
      end
      GRANT: begin
        if (!hrq)
          w_state_nxt = RELEASE;
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The first GRANT cycle is a handover cycle; hlda drops on the same edge GRANT is left.
  always_comb begin
    w_hlda_nxt  = (r_state == GRANT) && (w_state_nxt == GRANT);
    w_grant_nxt = (w_state_nxt == IDLE) && cpuBusReq;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hlda      <= 1'b0;
      r_cpu_grant <= 1'b0;
      r_dly_cnt   <= 4'd0;
      r_fair_cnt  <= 4'd0;
    end else begin
      r_hlda      <= w_hlda_nxt;
      r_cpu_grant <= w_grant_nxt;

      if ((w_state_nxt == DELAY) && (r_state != DELAY))
        r_dly_cnt <= DLY_LOAD;
      else if ((r_state == DELAY) && (r_dly_cnt != 4'd0))
        r_dly_cnt <= r_dly_cnt - 4'd1;

      if (r_state == RELEASE)
        r_fair_cnt <= cpuBusReq ? FAIR_LOAD : 4'd0;
      else if ((r_state != IDLE) || !cpuBusReq)
        r_fair_cnt <= 4'd0;
      else if (r_fair_cnt != 4'd0)
        r_fair_cnt <= r_fair_cnt - 4'd1;
    end
  end

  assign hlda     = r_hlda;
  assign cpuGrant = r_cpu_grant;

`ifdef HOLD_WATCHDOG_EN
  logic w_in_grant;
  logic w_hold_err;

  assign w_in_grant = (r_state == GRANT);

  hold_watchdog #(
    .WDOG_MAX (WDOG_MAX),
    .WDOG_W   (WDOG_W)
  ) u_wdog (
    .CLK   (CLK),
    .RESET (RESET),
    .i_run (w_in_grant),
    .o_err (w_hold_err)
  );

  assign holdErr = w_hold_err;
`else
  assign holdErr = 1'b0;
`endif

endmodule

// File: tb/tb_dma_hold_ctrl.sv
// Bench for dma_hold_ctrl: directed vector table, hand sequences and a random run
// checked against a cycle-level ownership model.
module tb_dma_hold_ctrl;

  localparam int P_DELAY = 1;
  localparam int P_MIN   = 1;
  localparam int P_WMAX  = 8;
  localparam int P_WW    = 4;
`ifdef HOLD_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic hrq = 1'b0;
  logic cpuBusReq = 1'b0;
  logic cpuCycleActive = 1'b0;
  logic cpuLock = 1'b0;
  logic hlda;
  logic cpuGrant;
  logic holdErr;

  always #5 CLK = ~CLK;

  dma_hold_ctrl #(
    .HLDA_DELAY     (P_DELAY),
    .CPU_MIN_CYCLES (P_MIN),
    .WDOG_MAX       (P_WMAX),
    .WDOG_W         (P_WW)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .hrq            (hrq),
    .cpuBusReq      (cpuBusReq),
    .cpuCycleActive (cpuCycleActive),
    .cpuLock        (cpuLock),
    .hlda           (hlda),
    .cpuGrant       (cpuGrant),
    .holdErr        (holdErr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Ownership model: 0 = CPU side, 1 = DMA holds bus, 2 = turnaround cycle.
  int m_phase    = 0;
  int m_run      = 0;   // consecutive edges with an unblocked request and a free bus
  int m_fair     = 0;   // remaining edges in which a pending CPU request blocks hrq
  int m_hold_age = 0;   // edges spent holding the bus
  bit m_hlda = 1'b0;
  bit m_grant = 1'b0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got {hlda,cpuGrant,holdErr}=%b expected %b at t=%0t", name, act, exp, $time);
  endtask

  function automatic void model_step();
    bit blocked;
    bit want;
    if (RESET) begin
      m_phase = 0; m_run = 0; m_fair = 0; m_hold_age = 0;
      m_hlda = 1'b0; m_grant = 1'b0; m_err = 1'b0;
    end else if (m_phase == 0) begin
      blocked = (m_fair > 0) && cpuBusReq;
      m_fair  = (cpuBusReq && m_fair > 0) ? m_fair - 1 : 0;
      want    = hrq && !blocked;
      if (!want || cpuCycleActive || cpuLock)
        m_run = 0;
      else
        m_run++;
      m_hlda  = 1'b0;
      m_grant = cpuBusReq && !want;
      if (want && m_run == P_DELAY + 1) begin
        m_phase = 1;
        m_hold_age = 0;
      end
    end else if (m_phase == 1) begin
      m_hold_age++;
      if (WD_ON && m_hold_age == P_WMAX)
        m_err = 1'b1;
      m_grant = 1'b0;
      m_hlda  = hrq;
      if (!hrq)
        m_phase = 2;
    end else begin
      m_phase = 0;
      m_run   = 0;
      m_fair  = cpuBusReq ? ((P_MIN > 0) ? P_MIN - 1 : 0) : 0;
      m_hlda  = 1'b0;
      m_grant = cpuBusReq;
    end
  endfunction

  task automatic drive(input bit r, input bit h, input bit b, input bit a, input bit l);
    RESET = r; hrq = h; cpuBusReq = b; cpuCycleActive = a; cpuLock = l;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check(tag, {hlda, cpuGrant, holdErr}, {m_hlda, m_grant, m_err});
  endtask

  typedef struct {
    bit rst; bit hrq; bit breq; bit act; bit lock; bit eh; bit eg;
  } vec_t;

  vec_t tbl[37];

  initial begin
    // rst hrq breq act lock | hlda cpuGrant after the edge
    tbl[0]  = '{1,0,0,0,0, 0,0};
    tbl[1]  = '{0,0,0,0,0, 0,0};
    tbl[2]  = '{0,1,0,0,0, 0,0};
    tbl[3]  = '{0,1,0,0,0, 0,0};
    tbl[4]  = '{0,1,0,0,0, 1,0};
    tbl[5]  = '{0,1,0,0,0, 1,0};
    tbl[6]  = '{0,0,0,0,0, 0,0};
    tbl[7]  = '{0,0,0,0,0, 0,0};
    tbl[8]  = '{0,1,1,0,0, 0,0};
    tbl[9]  = '{0,0,1,0,0, 0,1};
    tbl[10] = '{0,0,1,0,0, 0,1};
    tbl[11] = '{0,0,0,0,0, 0,0};
    tbl[12] = '{0,1,1,0,0, 0,0};
    tbl[13] = '{0,1,1,0,0, 0,0};
    tbl[14] = '{0,1,1,0,0, 1,0};
    tbl[15] = '{0,0,1,0,0, 0,0};
    tbl[16] = '{0,1,1,0,0, 0,1};
    tbl[17] = '{0,1,1,0,0, 0,0};
    tbl[18] = '{0,1,1,0,0, 0,0};
    tbl[19] = '{0,1,1,0,0, 1,0};
    tbl[20] = '{1,1,0,0,0, 0,0};
    tbl[21] = '{0,0,0,0,0, 0,0};
    tbl[22] = '{0,1,0,0,1, 0,0};
    tbl[23] = '{0,1,0,0,1, 0,0};
    tbl[24] = '{0,1,0,0,0, 0,0};
    tbl[25] = '{0,1,0,0,0, 0,0};
    tbl[26] = '{0,1,0,0,0, 1,0};
    tbl[27] = '{0,0,0,0,0, 0,0};
    tbl[28] = '{0,0,1,0,0, 0,1};
    tbl[29] = '{0,0,0,0,0, 0,0};
    tbl[30] = '{0,1,0,0,0, 0,0};
    tbl[31] = '{0,1,0,1,0, 0,0};
    tbl[32] = '{0,1,0,0,0, 0,0};
    tbl[33] = '{0,1,0,0,0, 0,0};
    tbl[34] = '{0,1,0,0,0, 1,0};
    tbl[35] = '{0,0,0,0,0, 0,0};
    tbl[36] = '{0,0,0,0,0, 0,0};

    for (int i = 0; i < 37; i++) begin
      drive(tbl[i].rst, tbl[i].hrq, tbl[i].breq, tbl[i].act, tbl[i].lock);
      cycle("model_vec");
      check($sformatf("vec%0d", i), {hlda, cpuGrant, holdErr}, {tbl[i].eh, tbl[i].eg, 1'b0});
    end

    // CPU cycle in flight for 4 edges when hrq rises
    drive(0, 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle("model_drain");
      check($sformatf("drain_wait%0d", k), {hlda, cpuGrant, holdErr}, 3'b000);
    end
    drive(0, 1, 0, 0, 0);
    cycle("model_drain");
    check("drain_plus1", {hlda, cpuGrant, holdErr}, 3'b000);
    cycle("model_drain");
    check("drain_plus2", {hlda, cpuGrant, holdErr}, 3'b000);
    cycle("model_drain");
    check("drain_grant", {hlda, cpuGrant, holdErr}, 3'b100);
    drive(0, 0, 0, 0, 0);
    cycle("model_drain");
    check("drain_release", {hlda, cpuGrant, holdErr}, 3'b000);
    cycle("model_drain");

    // Long hold: holdErr must appear from hold cycle WDOG_MAX when the watchdog is built
    drive(1, 0, 0, 0, 0);
    cycle("model_wdog");
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle("model_wdog");
      check($sformatf("wdog_edge%0d", k), {hlda, cpuGrant, holdErr},
            {(k >= 3), 1'b0, (WD_ON && (k >= P_WMAX + 2))});
    end
    drive(0, 0, 0, 0, 0);
    cycle("model_wdog");
    check("wdog_release", {hlda, cpuGrant, holdErr}, {2'b00, WD_ON});
    cycle("model_wdog");
    cycle("model_wdog");
    check("wdog_sticky", {hlda, cpuGrant, holdErr}, {2'b00, WD_ON});
    drive(1, 0, 0, 0, 0);
    cycle("model_wdog");
    check("wdog_reset", {hlda, cpuGrant, holdErr}, 3'b000);

    // Random traffic against the model
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) hrq = ~hrq;
      if ($urandom_range(0, 3) == 0) cpuBusReq = ~cpuBusReq;
      if ($urandom_range(0, 3) == 0) cpuCycleActive = ~cpuCycleActive;
      if ($urandom_range(0, 11) == 0) cpuLock = ~cpuLock;
      cycle("model_rand");
      check("rand_exclusive", {1'b0, hlda & cpuGrant, 1'b0}, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
